// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: watch/set/stopwatch/timer/alarm FSM.
// Ports: clk, reset_n (sync, low); one-cycle UI pulses mode_short,
//   mode_long, field_pulse, inc_pulse, start_pulse; tick_sec,
//   timer_done; cur_* live watch BCD. Outputs (all registered):
//   mode, load_en/load_sel/load_* edit buffer, edit_field, sw_run,
//   sw_clear, tmr_run, alarm.
module watch_mode_ctrl #(
   parameter int unsigned ALARM_SEC = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       mode_short,
   input  logic       mode_long,
   input  logic       field_pulse,
   input  logic       inc_pulse,
   input  logic       start_pulse,
   input  logic       tick_sec,
   input  logic       timer_done,
   input  logic [3:0] cur_min10,
   input  logic [3:0] cur_min1,
   input  logic [3:0] cur_sec10,
   input  logic [3:0] cur_sec1,
   output logic [2:0] mode,
   output logic       load_en,
   output logic       load_sel,
   output logic [3:0] load_min10,
   output logic [3:0] load_min1,
   output logic [3:0] load_sec10,
   output logic [3:0] load_sec1,
   output logic       edit_field,
   output logic       sw_run,
   output logic       sw_clear,
   output logic       tmr_run,
   output logic       alarm
);

   localparam logic [2:0] S_WATCH = 3'd0;
   localparam logic [2:0] S_WSET  = 3'd1;
   localparam logic [2:0] S_SW    = 3'd2;
   localparam logic [2:0] S_TSET  = 3'd3;
   localparam logic [2:0] S_TRUN  = 3'd4;
   localparam logic [2:0] S_ALARM = 3'd5;

   localparam logic [7:0] ALARM_N = 8'(ALARM_SEC);

   logic [2:0]  state;
   logic [7:0]  alarm_cnt;
   logic [15:0] edit_buf;
   logic [7:0]  sec_nx;
   logic [7:0]  min_nx;
   logic [15:0] inc_buf;

   assign mode = state;
   assign {load_min10, load_min1, load_sec10, load_sec1} = edit_buf;

   // 00..59 BCD increment; wraps without carrying out.
   function automatic logic [7:0] bcd_inc(
      input logic [3:0] hi,
      input logic [3:0] lo
   );
      logic [3:0] h;
      if (lo >= 4'd9) begin
         h = (hi >= 4'd5) ? 4'd0 : hi + 4'd1;
         return {h, 4'd0};
      end
      return {hi, lo + 4'd1};
   endfunction

   always_comb begin
      sec_nx  = bcd_inc(edit_buf[7:4], edit_buf[3:0]);
      min_nx  = bcd_inc(edit_buf[15:12], edit_buf[11:8]);
      inc_buf = edit_field ? {min_nx, edit_buf[7:0]}
                           : {edit_buf[15:8], sec_nx};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_WATCH;
         load_en    <= 1'b0;
         load_sel   <= 1'b0;
         edit_buf   <= '0;
         edit_field <= 1'b0;
         sw_run     <= 1'b0;
         sw_clear   <= 1'b0;
         tmr_run    <= 1'b0;
         alarm      <= 1'b0;
         alarm_cnt  <= '0;
      end else begin
         load_en  <= 1'b0;
         sw_clear <= 1'b0;
         // Each arm checks only its own events, highest priority first.
         unique case (state)
            S_WATCH: begin
               if (mode_long) begin
                  state      <= S_WSET;
                  edit_buf   <= {cur_min10, cur_min1,
                                 cur_sec10, cur_sec1};
                  edit_field <= 1'b0;
               end else if (mode_short) begin
                  state <= S_SW;
               end
            end
            S_WSET: begin
               if (mode_long) begin
                  state    <= S_WATCH;
                  load_en  <= 1'b1;
                  load_sel <= 1'b0;
               end else if (field_pulse) begin
                  edit_field <= ~edit_field;
               end else if (inc_pulse) begin
                  edit_buf <= inc_buf;
               end
            end
            S_SW: begin
               if (mode_long) begin
                  if (!sw_run) sw_clear <= 1'b1;
               end else if (mode_short) begin
                  state      <= S_TSET;
                  edit_buf   <= '0;
                  edit_field <= 1'b0;
               end else if (start_pulse) begin
                  sw_run <= ~sw_run;
               end
            end
            S_TSET: begin
               if (mode_short) begin
                  state <= S_WATCH;
               end else if (start_pulse) begin
                  if (edit_buf != '0) begin
                     state    <= S_TRUN;
                     load_en  <= 1'b1;
                     load_sel <= 1'b1;
                     tmr_run  <= 1'b1;
                  end
               end else if (field_pulse) begin
                  edit_field <= ~edit_field;
               end else if (inc_pulse) begin
                  edit_buf <= inc_buf;
               end
            end
            S_TRUN: begin
               // Borrow-out ends the run even while paused.
               if (timer_done) begin
                  state     <= S_ALARM;
                  tmr_run   <= 1'b0;
                  alarm     <= 1'b1;
                  alarm_cnt <= '0;
               end else if (mode_short) begin
                  state      <= S_TSET;
                  tmr_run    <= 1'b0;
                  edit_buf   <= '0;
                  edit_field <= 1'b0;
               end else if (start_pulse) begin
                  tmr_run <= ~tmr_run;
               end
            end
            S_ALARM: begin
               if (mode_short || mode_long || start_pulse ||
                   (tick_sec && (alarm_cnt + 8'd1 >= ALARM_N))) begin
                  state      <= S_TSET;
                  alarm      <= 1'b0;
                  edit_buf   <= '0;
                  edit_field <= 1'b0;
               end else if (tick_sec) begin
                  alarm_cnt <= alarm_cnt + 8'd1;
               end
            end
            default: begin
               state <= S_WATCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed self-checking bench for watch_mode_ctrl.
// Inputs change 1 ns after posedge; outputs checked there too.
module tb_watch_mode_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       mode_short, mode_long, field_pulse, inc_pulse;
   logic       start_pulse, tick_sec, timer_done;
   logic [3:0] cur_min10, cur_min1, cur_sec10, cur_sec1;
   logic [2:0] mode;
   logic       load_en, load_sel;
   logic [3:0] load_min10, load_min1, load_sec10, load_sec1;
   logic       edit_field, sw_run, sw_clear, tmr_run, alarm;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   watch_mode_ctrl #(.ALARM_SEC(10)) dut (
      .clk(clk), .reset_n(reset_n),
      .mode_short(mode_short), .mode_long(mode_long),
      .field_pulse(field_pulse), .inc_pulse(inc_pulse),
      .start_pulse(start_pulse), .tick_sec(tick_sec),
      .timer_done(timer_done),
      .cur_min10(cur_min10), .cur_min1(cur_min1),
      .cur_sec10(cur_sec10), .cur_sec1(cur_sec1),
      .mode(mode), .load_en(load_en), .load_sel(load_sel),
      .load_min10(load_min10), .load_min1(load_min1),
      .load_sec10(load_sec10), .load_sec1(load_sec1),
      .edit_field(edit_field), .sw_run(sw_run),
      .sw_clear(sw_clear), .tmr_run(tmr_run), .alarm(alarm)
   );

   wire [15:0] buf_v = {load_min10, load_min1, load_sec10, load_sec1};

   task automatic step();
      @(posedge clk);
      #1;
      mode_short  = 1'b0;
      mode_long   = 1'b0;
      field_pulse = 1'b0;
      inc_pulse   = 1'b0;
      start_pulse = 1'b0;
      tick_sec    = 1'b0;
      timer_done  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   initial begin
      reset_n = 1'b0;
      mode_short = 0; mode_long = 0; field_pulse = 0;
      inc_pulse = 0; start_pulse = 0; tick_sec = 0; timer_done = 0;
      {cur_min10, cur_min1, cur_sec10, cur_sec1} = 16'h1234;
      step(); step();
      chk("rst_mode", 32'(mode), 0);
      chk("rst_load_en", 32'(load_en), 0);
      chk("rst_buf", 32'(buf_v), 0);
      chk("rst_flags", 32'({sw_run, sw_clear, tmr_run, alarm}), 0);
      reset_n = 1'b1;
      step();
      chk("idle_mode", 32'(mode), 0);

      // set watch
      mode_long = 1; step();
      chk("wset_mode", 32'(mode), 1);
      chk("wset_cap", 32'(buf_v), 32'h1234);
      chk("wset_field0", 32'(edit_field), 0);
      field_pulse = 1; step();
      chk("wset_field1", 32'(edit_field), 1);
      for (int i = 0; i < 26; i++) begin
         inc_pulse = 1; step();
      end
      chk("wset_min38", 32'(buf_v), 32'h3834);
      mode_long = 1; step();
      chk("commit_en", 32'(load_en), 1);
      chk("commit_sel", 32'(load_sel), 0);
      chk("commit_buf", 32'(buf_v), 32'h3834);
      chk("commit_mode", 32'(mode), 0);
      step();
      chk("commit_1cyc", 32'(load_en), 0);

      // seconds wrap, then reset during load_en
      {cur_min10, cur_min1, cur_sec10, cur_sec1} = 16'h1258;
      mode_long = 1; step();
      inc_pulse = 1; step();
      chk("sec59", 32'(buf_v), 32'h1259);
      inc_pulse = 1; step();
      chk("sec_wrap", 32'(buf_v), 32'h1200);
      mode_long = 1; step();
      chk("ld_before_rst", 32'(load_en), 1);
      reset_n = 1'b0; step();
      chk("rst_ld_en", 32'(load_en), 0);
      chk("rst_ld_buf", 32'(buf_v), 0);
      chk("rst_ld_mode", 32'(mode), 0);
      chk("rst_ld_sel", 32'(load_sel), 0);
      reset_n = 1'b1; step();

      // stopwatch
      mode_short = 1; step();
      chk("sw_mode", 32'(mode), 2);
      start_pulse = 1; step();
      chk("sw_run1", 32'(sw_run), 1);
      mode_long = 1; step();
      chk("sw_noclr", 32'(sw_clear), 0);
      start_pulse = 1; step();
      chk("sw_run0", 32'(sw_run), 0);
      mode_long = 1; step();
      chk("sw_clr", 32'(sw_clear), 1);
      step();
      chk("sw_clr_1cyc", 32'(sw_clear), 0);
      start_pulse = 1; step();
      mode_short = 1; step();
      chk("tset_mode", 32'(mode), 3);
      chk("tset_bg_run", 32'(sw_run), 1);
      chk("tset_buf0", 32'(buf_v), 0);

      // timer
      start_pulse = 1; step();
      chk("tset_zero_ign", 32'(mode), 3);
      chk("tset_zero_ld", 32'(load_en), 0);
      timer_done = 1; step();
      chk("tset_done_ign", 32'(mode), 3);
      for (int i = 0; i < 5; i++) begin
         inc_pulse = 1; step();
      end
      chk("tset_buf5", 32'(buf_v), 32'h0005);
      start_pulse = 1; step();
      chk("trun_ld", 32'(load_en), 1);
      chk("trun_sel", 32'(load_sel), 1);
      chk("trun_buf", 32'(buf_v), 32'h0005);
      chk("trun_mode", 32'(mode), 4);
      chk("trun_run", 32'(tmr_run), 1);
      step();
      chk("trun_ld_1cyc", 32'(load_en), 0);
      start_pulse = 1; step();
      chk("trun_pause", 32'(tmr_run), 0);
      timer_done = 1; mode_short = 1; step();
      chk("prio_mode", 32'(mode), 5);
      chk("prio_alarm", 32'(alarm), 1);
      chk("prio_run", 32'(tmr_run), 0);
      for (int i = 0; i < 9; i++) begin
         tick_sec = 1; step(); step();
      end
      chk("alarm_9s", 32'(mode), 5);
      tick_sec = 1; step();
      chk("alarm_10s", 32'(mode), 3);
      chk("alarm_off", 32'(alarm), 0);

      // minutes field in TIMER_SET, then back to WATCH
      field_pulse = 1; step();
      inc_pulse = 1; step();
      chk("tset_min", 32'(buf_v), 32'h0100);
      mode_short = 1; step();
      chk("back_watch", 32'(mode), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
